// File: rtl/reset_watchdog_pkg.sv
// reset_watchdog_pkg: state encoding, register map and magic values for the reset watchdog
package reset_watchdog_pkg;
  typedef enum logic [1:0] {
    DISABLED   = 2'd0,
    RUNNING    = 2'd1,
    REQUESTING = 2'd2,
    HALTED     = 2'd3
  } state_e;
  localparam logic [1:0] ADDR_CONTROL = 2'd0;
  localparam logic [1:0] ADDR_RELOAD  = 2'd1;
  localparam logic [1:0] ADDR_KICK    = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;
  localparam logic [31:0] KICK_MAGIC    = 32'h4B1C_4B1C;
  localparam logic [31:0] REQUEST_MAGIC = 32'hDEAD_0001;
endpackage

// File: rtl/reset_watchdog.sv
// reset_watchdog: bus-programmed watchdog that issues a fixed-length registered reset request
module reset_watchdog
  import reset_watchdog_pkg::*;
#(
  parameter int TIMEOUT_WIDTH = 24,
  parameter int PULSE_CYCLES  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        write,
  input  logic [1:0]  address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        acknowledge,
  output logic        resetRequest
);
  localparam logic [TIMEOUT_WIDTH-1:0] PULSE_LAST = TIMEOUT_WIDTH'(PULSE_CYCLES - 1);
  localparam logic [TIMEOUT_WIDTH-1:0] ONE = TIMEOUT_WIDTH'(1);
  state_e state_q, state_d;
  logic [TIMEOUT_WIDTH-1:0] count_q, count_d, reload_q, reload_d;
  logic lock_q, lock_d, ack_q, ack_d, req_q, req_d;
  logic [31:0] rdata_q, rdata_d, rd_sel;
  logic wr, wr_ctrl, wr_reload, wr_kick, kick_ok, magic;
  assign readData = rdata_q;
  assign acknowledge = ack_q;
  assign resetRequest = req_q;
  // Bus decode plus watchdog FSM/counter next state; writes commit at the edge ending the ack cycle
  always_comb begin
    wr = enable & write & ack_q & (state_q != REQUESTING);
    wr_ctrl = wr & (address == ADDR_CONTROL);
    wr_reload = wr & (address == ADDR_RELOAD);
    wr_kick = wr & (address == ADDR_KICK);
    magic = wr & (address == ADDR_STATUS) & (writeData == REQUEST_MAGIC);
    kick_ok = writeData == KICK_MAGIC;
    ack_d = enable & ~ack_q;
    rd_sel = address == ADDR_CONTROL ? {30'b0, lock_q, state_q == RUNNING} :
             address == ADDR_RELOAD  ? 32'(reload_q) :
             address == ADDR_STATUS  ? {state_q, 30'(count_q)} : 32'b0;
    rdata_d = (enable & ~ack_q & ~write) ? rd_sel : 32'b0;
    req_d = state_q == REQUESTING;
    state_d = state_q;
    count_d = count_q;
    lock_d = lock_q;
    reload_d = wr_reload ? writeData[TIMEOUT_WIDTH-1:0] : reload_q;
    case (state_q)
      DISABLED:
        if (magic) begin
          state_d = REQUESTING;
          count_d = PULSE_LAST;
        end else if (wr_ctrl & writeData[0]) begin
          state_d = RUNNING;
          count_d = reload_q;
          lock_d = writeData[1];
        end
      RUNNING:
        if (magic | (wr_kick & ~kick_ok) | (~wr_kick & ~(wr_ctrl & ~writeData[0] & ~lock_q) & count_q == '0)) begin
          state_d = REQUESTING;
          count_d = PULSE_LAST;
        end else if (wr_kick) begin
          count_d = reload_q;
        end else if (wr_ctrl & ~writeData[0] & ~lock_q) begin
          state_d = DISABLED;
        end else begin
          count_d = count_q - ONE;
        end
      REQUESTING:
        if (count_q == '0) state_d = HALTED;
        else count_d = count_q - ONE;
      HALTED: state_d = HALTED;
    endcase
  end
  // State, counter and bus registers; reset clears the request asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= DISABLED;
      count_q <= '0;
      reload_q <= '1;
      lock_q <= 1'b0;
      ack_q <= 1'b0;
      req_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      reload_q <= reload_d;
      lock_q <= lock_d;
      ack_q <= ack_d;
      req_q <= req_d;
      rdata_q <= rdata_d;
    end
  end
endmodule

// File: tb/tb_reset_watchdog.sv
// tb_reset_watchdog: table-driven register checks plus directed timeout/kick/reset sequences
module tb_reset_watchdog;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b0, write = 1'b0;
  logic [1:0] address = '0;
  logic [31:0] writeData = '0, readData;
  logic acknowledge, resetRequest;
  int checks = 0, failures = 0;

  typedef struct {
    logic        w;
    logic [1:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[16];

  reset_watchdog dut (
    .clk(clk), .reset(reset), .enable(enable), .write(write), .address(address),
    .writeData(writeData), .readData(readData), .acknowledge(acknowledge),
    .resetRequest(resetRequest)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout act=running req=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    enable = 1'b0;
    write = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the commit edge
  task automatic access(input logic w, input logic [1:0] a, input logic [31:0] d, output logic [31:0] rd);
    enable = 1'b1;
    write = w;
    address = a;
    writeData = d;
    @(posedge clk);
    @(negedge clk);
    check("ack_high", 32'(acknowledge), 32'd1);
    rd = readData;
    @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    write = 1'b0;
    check("ack_low", 32'(acknowledge), 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [31:0] rd;
  int seen;

  initial begin
    vecs[0]  = '{1'b0, 2'd1, 32'h0,         32'h00FF_FFFF};
    vecs[1]  = '{1'b0, 2'd0, 32'h0,         32'h0};
    vecs[2]  = '{1'b0, 2'd2, 32'h0,         32'h0};
    vecs[3]  = '{1'b0, 2'd3, 32'h0,         32'h0};
    vecs[4]  = '{1'b1, 2'd1, 32'h1234_5678, 32'h0};
    vecs[5]  = '{1'b0, 2'd1, 32'h0,         32'h0034_5678};
    vecs[6]  = '{1'b1, 2'd2, 32'h4B1C_4B1C, 32'h0};
    vecs[7]  = '{1'b1, 2'd3, 32'hDEAD_0002, 32'h0};
    vecs[8]  = '{1'b0, 2'd3, 32'h0,         32'h0};
    vecs[9]  = '{1'b1, 2'd1, 32'h5,         32'h0};
    vecs[10] = '{1'b1, 2'd0, 32'h1,         32'h0};
    vecs[11] = '{1'b0, 2'd3, 32'h0,         32'h4000_0005};
    vecs[12] = '{1'b0, 2'd3, 32'h0,         32'h4000_0003};
    vecs[13] = '{1'b1, 2'd2, 32'h4B1C_4B1C, 32'h0};
    vecs[14] = '{1'b0, 2'd3, 32'h0,         32'h4000_0005};
    vecs[15] = '{1'b0, 2'd0, 32'h0,         32'h1};

    @(negedge clk);
    check("reset_ack", 32'(acknowledge), 32'd0);
    check("reset_rdata", readData, 32'h0);
    check("reset_req", 32'(resetRequest), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      access(vecs[i].w, vecs[i].a, vecs[i].d, rd);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
      check($sformatf("vec%0d_req", i), 32'(resetRequest), 32'd0);
    end

    // Timeout with reload 10: request rises 12 edges after arming and lasts 16 cycles
    do_reset();
    access(1'b1, 2'd1, 32'd10, rd);
    access(1'b1, 2'd0, 32'd1, rd);
    for (int k = 1; k <= 40; k++) begin
      tick();
      check($sformatf("timeout_req_k%0d", k), 32'(resetRequest), 32'((k >= 12) && (k <= 27)));
    end
    access(1'b0, 2'd3, 32'h0, rd);
    check("halted_status", rd, 32'hC000_0000);

    // Periodic good kicks hold off the timeout; a bad kick requests reset
    do_reset();
    access(1'b1, 2'd1, 32'd100, rd);
    access(1'b1, 2'd0, 32'd1, rd);
    seen = 0;
    for (int n = 0; n < 20; n++) begin
      for (int c = 0; c < 47; c++) begin
        tick();
        if (resetRequest) seen++;
      end
      access(1'b1, 2'd2, 32'h4B1C_4B1C, rd);
    end
    check("kick_no_req", 32'(seen), 32'd0);
    access(1'b1, 2'd2, 32'h0, rd);
    check("badkick_req_first", 32'(resetRequest), 32'd0);
    tick();
    check("badkick_req_second", 32'(resetRequest), 32'd1);

    // Locked watchdog ignores the disable write and still times out
    do_reset();
    access(1'b1, 2'd1, 32'd20, rd);
    access(1'b1, 2'd0, 32'd3, rd);
    access(1'b1, 2'd0, 32'd0, rd);
    access(1'b0, 2'd3, 32'h0, rd);
    check("lock_state", 32'(rd[31:30]), 32'd1);
    seen = 0;
    for (int c = 0; c < 60 && seen == 0; c++) begin
      tick();
      if (resetRequest) seen = 1;
    end
    check("lock_timeout_fires", 32'(seen), 32'd1);

    // Unlocked disable returns to DISABLED
    do_reset();
    access(1'b1, 2'd0, 32'd1, rd);
    access(1'b1, 2'd0, 32'd0, rd);
    access(1'b0, 2'd3, 32'h0, rd);
    check("unlock_state", 32'(rd[31:30]), 32'd0);

    // Reload 0 times out on the first running cycle; reset mid-pulse clears everything
    do_reset();
    access(1'b1, 2'd1, 32'd0, rd);
    access(1'b1, 2'd0, 32'd1, rd);
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("zero_reload_req_k%0d", k), 32'(resetRequest), 32'(k >= 2));
    end
    reset = 1'b1;
    #1;
    check("async_reset_req", 32'(resetRequest), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    access(1'b0, 2'd3, 32'h0, rd);
    check("post_reset_status", rd, 32'h0);
    access(1'b0, 2'd1, 32'h0, rd);
    check("post_reset_reload", rd, 32'h00FF_FFFF);

    // Software reset request via magic write while DISABLED
    do_reset();
    access(1'b1, 2'd3, 32'hDEAD_0001, rd);
    for (int k = 1; k <= 20; k++) begin
      tick();
      check($sformatf("magic_req_k%0d", k), 32'(resetRequest), 32'(k <= 16));
    end
    do_reset();
    access(1'b1, 2'd3, 32'hDEAD_0002, rd);
    seen = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (resetRequest) seen++;
    end
    check("wrong_magic_no_req", 32'(seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reset_watchdog.md
# reset_watchdog

Watchdog timer that drives the reset-request input of the clock/reset generator, acting as the requesting side of the reset path. Software arms it and periodically kicks it over a simple single-word bus slave port; on timeout, a bad kick value or an explicit software request, it issues a fixed-length, registered reset-request pulse. That pulse drives the generator's `resetIn`, which synchronizes it and stretches it into the system reset. The system reset then returns to this block on `reset`.

## Interface
- `TIMEOUT_WIDTH`, 24: width of the reload and count registers.
- `PULSE_CYCLES`, 16: length of the reset-request pulse in `clk` cycles. Must be ≥4 so the generator's two-flop synchronizer always captures it.

- `clk` input 1: system clock.
- `reset` input 1: asynchronous, active-high reset.
- `enable` input 1: bus access strobe, held until `acknowledge`.
- `write` input 1: 1 = write, 0 = read; valid while `enable`.
- `address` input 2: register select.
- `writeData` input 32: write data.
- `readData` output 32: read data, valid in the `acknowledge` cycle, 0 otherwise.
- `acknowledge` output 1: one-cycle access completion.
- `resetRequest` output 1: registered request to the reset generator.

## Operation
- Registers:
  - addr 0, control: bit0 `run`, bit1 `lock`.
  - addr 1, reload: `TIMEOUT_WIDTH` bits. Upper write bits are ignored; read is zero-extended.
  - addr 2, kick: write-only; reads as 0.
  - addr 3, status: bits 31:30 state, bits `TIMEOUT_WIDTH-1`:0 current count, other bits 0. Writing the magic value 32'hDEAD_0001 requests reset; other writes are ignored.
- Reset values:
  - `readData`=0, `acknowledge`=0, `resetRequest`=0.
  - state DISABLED, count 0, reload all ones, lock 0.
- Bus: `acknowledge` <= `enable` & ~`acknowledge`. Writes take effect on the clock edge that ends the `acknowledge` cycle.
- States:
  - DISABLED:
    - Write control with bit0=1 → count <= reload, go to RUNNING.
    - Bit1 of that write sets `lock`. `lock` is sticky until `reset`.
  - RUNNING:
    - Each cycle: if count==0, go to REQUESTING; else count <= count-1.
    - Write control bit0=0 with `lock`=0 → DISABLED. With `lock`=1 the clear is ignored.
    - Kick write of 32'h4B1C_4B1C → count <= reload.
    - Kick write of any other value → REQUESTING.
  - REQUESTING:
    - count <= `PULSE_CYCLES`-1, then decrements to 0.
    - After the last pulse cycle → HALTED.
    - All writes are ignored; reads are still acknowledged.
  - HALTED: `resetRequest` low; leaves only via `reset`.
- Magic write to addr 3 → REQUESTING from DISABLED or RUNNING.
- Kick writes in DISABLED are ignored.
- Simultaneous events:
  - Valid kick in the same cycle as count==0 → the kick wins and the count is reloaded.
  - Bad kick or magic write in the same cycle as a timeout → REQUESTING, same result either way.
- Reload of 0 → timeout on the first RUNNING cycle.
- Writing reload while RUNNING does not change the current count until the next kick.

## Timing
- `resetRequest` is a registered state decode, high exactly while in REQUESTING: exactly `PULSE_CYCLES` cycles, glitch-free.
- Timeout: the first REQUESTING cycle is reload+1 cycles after the arming/kick edge. `resetRequest` rises one edge later.
- Bus latency: 1 cycle. Accesses on consecutive cycles are impossible because `acknowledge` is always followed by one idle cycle.
- `reset` asserted mid-pulse: `resetRequest` drops asynchronously and all state returns to reset values.

## Structure
- Package `reset_watchdog_pkg`:
  - state encoding DISABLED=2'd0, RUNNING=2'd1, REQUESTING=2'd2, HALTED=2'd3
  - register address constants
  - `KICK_MAGIC`=32'h4B1C_4B1C
  - `REQUEST_MAGIC`=32'hDEAD_0001
- Single module, no sub-modules. The bus decode and the FSM/counter share one always block pair (sequential plus next-state).

## Test plan
- Reset, then read addr 1 → `readData`=32'h00FF_FFFF, `acknowledge` high exactly 1 cycle; `resetRequest` stays 0.
- Reload=10, control=1 → `resetRequest` rises 12 edges after the control write edge and stays high exactly 16 cycles; state then reads 3.
- Reload=100, arm, kick 32'h4B1C_4B1C every 50 cycles for 1000 cycles → no request. Then kick 32'h0 → `resetRequest` high on the second edge after the write.
- Arm with control=3, then write control=0 → status state stays 1 and the timeout still fires.
- Reload=0, arm → request starts 1 cycle after RUNNING. Assert `reset` during pulse cycle 5 → `resetRequest` 0 immediately; status reads 0.
- Write 32'hDEAD_0001 to addr 3 while DISABLED → 16-cycle pulse. Writing 32'hDEAD_0002 → no pulse.
